// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard: saturating counters set at issue, cleared by two retire ports.
// Hazard/reserve outputs are combinational; counters, busy and err_underflow update on the next edge.
module reg_scoreboard #(
  parameter int CNT_W = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  output logic       rs1_valid,
  output logic       rs2_valid,
  input  logic [4:0] rd,
  input  logic       reserve,
  output logic       reserve_ok,
  input  logic [4:0] wreg0,
  input  logic       wen0,
  input  logic [4:0] wreg1,
  input  logic       wen1,
  input  logic       flush,
  output logic       busy,
  output logic       err_underflow
);

  localparam int SW = CNT_W + 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] pend_q [32];
  logic [CNT_W-1:0] pend_d [32];
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic [SW-1:0]    rel_rs1, rel_rs2;

  // Releases landing on a source this cycle are forwarded by the regfile write-through,
  // so they count towards clearing the hazard.
  always_comb begin
    rel_rs1 = SW'(wen0 && (wreg0 == rs1)) + SW'(wen1 && (wreg1 == rs1));
    rel_rs2 = SW'(wen0 && (wreg0 == rs2)) + SW'(wen1 && (wreg1 == rs2));
    rs1_valid  = (rs1 == 5'd0) || (rel_rs1 >= SW'(pend_q[rs1]));
    rs2_valid  = (rs2 == 5'd0) || (rel_rs2 >= SW'(pend_q[rs2]));
    reserve_ok = (rd == 5'd0) || (pend_q[rd] != CNT_MAX);
  end

  always_comb begin
    busy_d = 1'b0;
    err_d  = err_q;
    for (int r = 0; r < 32; r++) begin
      logic [SW-1:0] sum;
      logic [SW-1:0] dec;
      pend_d[r] = '0;
      sum = SW'(pend_q[r]) + SW'(reserve && reserve_ok && (rd == 5'(r)));
      dec = SW'(wen0 && (wreg0 == 5'(r))) + SW'(wen1 && (wreg1 == 5'(r)));
      // x0 is hardwired empty and flush discards everything, including releases.
      if (!flush && r != 0) begin
        if (dec > sum) begin
          err_d = 1'b1;
        end else begin
          pend_d[r] = CNT_W'(sum - dec);
        end
      end
      busy_d = busy_d | (pend_d[r] != '0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < 32; r++) pend_q[r] <= '0;
      busy_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      for (int r = 0; r < 32; r++) pend_q[r] <= pend_d[r];
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign busy          = busy_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed scoreboard bench for reg_scoreboard: the driver queues hand-computed expectations
// per cycle and an independent monitor compares them against the DUT on the falling edge.
module tb_reg_scoreboard;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] rs1, rs2, rd, wreg0, wreg1;
  logic       reserve, wen0, wen1, flush;
  logic       rs1_valid, rs2_valid, reserve_ok, busy, err_underflow;

  typedef struct {
    string      name;
    logic [4:0] mask;
    logic       rs1v, rs2v, rok, bsy, err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  localparam logic [4:0] M_R1 = 5'b10000, M_R2 = 5'b01000, M_OK = 5'b00100,
                         M_BS = 5'b00010, M_ER = 5'b00001, ALL = 5'b11111;

  always #5 clk = ~clk;

  reg_scoreboard #(.CNT_W(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .rs1(rs1), .rs2(rs2), .rs1_valid(rs1_valid), .rs2_valid(rs2_valid),
    .rd(rd), .reserve(reserve), .reserve_ok(reserve_ok),
    .wreg0(wreg0), .wen0(wen0), .wreg1(wreg1), .wen1(wen1),
    .flush(flush), .busy(busy), .err_underflow(err_underflow)
  );

  task automatic check(input string nm, input string fld, input logic got, input logic want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s.%s got %b expected %b", nm, fld, got, want);
    end
  endtask

  // Monitor: one expectation per driven cycle, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.mask[4]) check(e.name, "rs1_valid", rs1_valid, e.rs1v);
        if (e.mask[3]) check(e.name, "rs2_valid", rs2_valid, e.rs2v);
        if (e.mask[2]) check(e.name, "reserve_ok", reserve_ok, e.rok);
        if (e.mask[1]) check(e.name, "busy", busy, e.bsy);
        if (e.mask[0]) check(e.name, "err_underflow", err_underflow, e.err);
      end
    end
  end

  task automatic step(input string nm,
                      input logic [4:0] a_rs1, input logic [4:0] a_rs2,
                      input logic [4:0] a_rd, input logic a_res,
                      input logic [4:0] a_w0, input logic a_e0,
                      input logic [4:0] a_w1, input logic a_e1,
                      input logic a_fl, input logic a_rstn,
                      input logic [4:0] m,
                      input logic e_r1, input logic e_r2, input logic e_ok,
                      input logic e_bs, input logic e_er);
    exp_t e;
    @(posedge clk);
    #1;
    rs1 = a_rs1; rs2 = a_rs2; rd = a_rd; reserve = a_res;
    wreg0 = a_w0; wen0 = a_e0; wreg1 = a_w1; wen1 = a_e1;
    flush = a_fl; reset_n = a_rstn;
    e.name = nm; e.mask = m;
    e.rs1v = e_r1; e.rs2v = e_r2; e.rok = e_ok; e.bsy = e_bs; e.err = e_er;
    exp_q.push_back(e);
  endtask

  initial begin
    reset_n = 1'b0; rs1 = '0; rs2 = '0; rd = '0; reserve = 1'b0;
    wreg0 = '0; wen0 = 1'b0; wreg1 = '0; wen1 = 1'b0; flush = 1'b0;

    //    name        rs1 rs2 rd res w0 e0 w1 e1 fl rstn mask r1 r2 ok bs er
    step("reset",      0,  0,  0, 0, 0, 0, 0, 0, 0, 0, ALL, 1, 1, 1, 0, 0);

    // single reservation, released by the writeback port
    step("t1_res",     5,  0,  5, 1, 0, 0, 0, 0, 0, 1, ALL, 1, 1, 1, 0, 0);
    step("t1_wait1",   5,  0,  0, 0, 0, 0, 0, 0, 0, 1, ALL, 0, 1, 1, 1, 0);
    step("t1_wait2",   5,  0,  0, 0, 0, 0, 0, 0, 0, 1, ALL, 0, 1, 1, 1, 0);
    step("t1_rel",     5,  0,  0, 0, 0, 0, 5, 1, 0, 1, ALL, 1, 1, 1, 1, 0);
    step("t1_idle",    5,  0,  0, 0, 0, 0, 0, 0, 0, 1, ALL, 1, 1, 1, 0, 0);

    // saturation at 3, fourth reserve dropped, releases not credited to reserve_ok
    step("t2_r1",      7,  0,  7, 1, 0, 0, 0, 0, 0, 1, ALL, 1, 1, 1, 0, 0);
    step("t2_r2",      7,  0,  7, 1, 0, 0, 0, 0, 0, 1, ALL, 0, 1, 1, 1, 0);
    step("t2_r3",      7,  0,  7, 1, 0, 0, 0, 0, 0, 1, ALL, 0, 1, 1, 1, 0);
    step("t2_r4",      7,  0,  7, 1, 0, 0, 0, 0, 0, 1, ALL, 0, 1, 0, 1, 0);
    step("t2_d1",      7,  0,  7, 0, 7, 1, 0, 0, 0, 1, ALL, 0, 1, 0, 1, 0);
    step("t2_d2",      7,  0,  7, 0, 7, 1, 0, 0, 0, 1, ALL, 0, 1, 1, 1, 0);
    step("t2_d3",      7,  0,  7, 0, 7, 1, 0, 0, 0, 1, ALL, 1, 1, 1, 1, 0);
    step("t2_end",     7,  0,  7, 0, 0, 0, 0, 0, 0, 1, ALL, 1, 1, 1, 0, 0);

    // dual release of the same register
    step("t3_r1",      0,  9,  9, 1, 0, 0, 0, 0, 0, 1, ALL, 1, 1, 1, 0, 0);
    step("t3_r2",      0,  9,  9, 1, 0, 0, 0, 0, 0, 1, ALL, 1, 0, 1, 1, 0);
    step("t3_dual",    0,  9,  0, 0, 9, 1, 9, 1, 0, 1, ALL, 1, 1, 1, 1, 0);
    step("t3_end",     0,  9,  0, 0, 0, 0, 0, 0, 0, 1, ALL, 1, 1, 1, 0, 0);

    // same-cycle reserve and release nets to zero change
    step("t4_res",     3,  0,  3, 1, 0, 0, 0, 0, 0, 1, ALL, 1, 1, 1, 0, 0);
    step("t4_mix",     3,  0,  3, 1, 0, 0, 3, 1, 0, 1, ALL, 1, 1, 1, 1, 0);
    step("t4_hold",    3,  0,  0, 0, 0, 0, 0, 0, 0, 1, ALL, 0, 1, 1, 1, 0);
    step("t4_rel",     3,  0,  0, 0, 3, 1, 0, 0, 0, 1, ALL, 1, 1, 1, 1, 0);
    step("t4_end",     3,  0,  0, 0, 0, 0, 0, 0, 0, 1, ALL, 1, 1, 1, 0, 0);

    // x0 is never reserved and never underflows
    step("x0_mix",     0,  0,  0, 1, 0, 1, 0, 1, 0, 1, ALL, 1, 1, 1, 0, 0);
    step("x0_chk",     0,  0,  0, 0, 0, 0, 0, 0, 0, 1, ALL, 1, 1, 1, 0, 0);

    // flush drops everything; a later release then underflows
    step("t5_r4",      4,  8,  4, 1, 0, 0, 0, 0, 0, 1, ALL, 1, 1, 1, 0, 0);
    step("t5_r8a",     4,  8,  8, 1, 0, 0, 0, 0, 0, 1, ALL, 0, 1, 1, 1, 0);
    step("t5_r8b",     4,  8,  8, 1, 0, 0, 0, 0, 0, 1, ALL, 0, 0, 1, 1, 0);
    step("t5_flush",   4,  8, 12, 1, 0, 0,20, 1, 1, 1, ALL, 0, 0, 1, 1, 0);
    step("t5_post",   12,  8,  0, 0, 0, 0, 0, 0, 0, 1, ALL, 1, 1, 1, 0, 0);
    step("t5_under",   4,  0,  0, 0, 4, 1, 0, 0, 0, 1, ALL, 1, 1, 1, 0, 0);
    step("t5_err",     4,  0,  0, 0, 0, 0, 0, 0, 0, 1, ALL, 1, 1, 1, 0, 1);
    step("t5_sticky",  0,  0,  0, 0, 0, 0, 0, 0, 0, 1, ALL, 1, 1, 1, 0, 1);

    // asynchronous reset in the middle of an outstanding write
    step("t6_res",     6,  0,  6, 1, 0, 0, 0, 0, 0, 1, ALL, 1, 1, 1, 0, 1);
    step("t6_hold",    6,  0,  0, 0, 0, 0, 0, 0, 0, 1, ALL, 0, 1, 1, 1, 1);
    step("t6_rst",     6,  0,  0, 0, 0, 0, 0, 0, 0, 0, M_R1 | M_BS | M_ER, 1, 1, 1, 0, 0);
    step("t6_relse",   6,  0,  0, 0, 0, 0, 0, 0, 0, 1, ALL, 1, 1, 1, 0, 0);
    step("t6_end",     6,  0,  6, 0, 0, 0, 0, 0, 0, 1, ALL, 1, 1, 1, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain pending=%0d expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
